// File: rtl/bootram_pkg.sv
// Shared definitions for the boot RAM controller.
//   ADDR_W     : word-address width of each byte-lane RAM (2K x 8 lanes)
//   BYTE_LANES : number of byte lanes forming one bus word
//   CNT_W      : loader byte-counter width (word address + lane select)
//   state_e    : controller FSM states
package bootram_pkg;

    localparam int ADDR_W     = 11;
    localparam int BYTE_LANES = 4;
    localparam int CNT_W      = ADDR_W + 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCESS  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_RESP    = 3'd3,
        ST_PROG    = 3'd4
    } state_e;

endpackage

// File: rtl/bootram_loader.sv
// Byte loader bookkeeping: byte counter, sticky wrap flag and the
// prog_valid/prog_ready handshake. The parent turns an accepted byte into a
// registered single-lane RAM write.
//   clk, resetn    : clock, synchronous active-low reset
//   active_i       : parent FSM is in its programming state
//   busy_i         : a loader byte write is in flight this cycle
//   prog_en_i      : loader ownership level
//   prog_start_i   : clears counter and wrap flag
//   prog_valid_i   : byte offered
//   prog_ready_o   : byte can be taken this cycle
//   accept_o       : byte taken this cycle
//   byte_addr_o    : byte address the accepted byte is written to
//   prog_wrap_o    : counter has wrapped past the top address
module bootram_loader
    import bootram_pkg::*;
#(
    parameter int ADDR_W = bootram_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              active_i,
    input  logic              busy_i,
    input  logic              prog_en_i,
    input  logic              prog_start_i,
    input  logic              prog_valid_i,
    output logic              prog_ready_o,
    output logic              accept_o,
    output logic [ADDR_W+1:0] byte_addr_o,
    output logic              prog_wrap_o
);

    logic [ADDR_W+1:0] cnt_q, cnt_d;
    logic              wrap_q, wrap_d;

    assign prog_ready_o = active_i & prog_en_i & ~busy_i;
    assign accept_o     = prog_ready_o & prog_valid_i;
    // A start pulse coincident with a byte redirects that byte to address 0.
    assign byte_addr_o  = prog_start_i ? '0 : cnt_q;
    assign prog_wrap_o  = wrap_q;

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = wrap_q;
        if (prog_start_i) begin
            cnt_d  = '0;
            wrap_d = 1'b0;
        end
        if (accept_o) begin
            cnt_d = byte_addr_o + 1'b1;
            if (byte_addr_o == '1) begin
                wrap_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

endmodule

// File: rtl/bootram_ctrl.sv
// Boot RAM controller: bridges a native CPU bus and a byte loader onto a set
// of external byte-lane RAMs (1-cycle read latency). All RAM-side outputs are
// registered.
//   clk, resetn              : clock, synchronous active-low reset
//   mem_valid/addr/wdata/wstrb: CPU request (wstrb == 0 means read)
//   mem_ready, mem_rdata     : one-cycle completion pulse and read data
//   prog_en/start/valid/data : loader control and byte stream
//   prog_ready, prog_wrap    : loader handshake and sticky wrap flag
//   ram_ad/ce/oce/wre/din    : shared lane RAM controls
//   ram_dout                 : lane RAM read data
//
// state   | meaning
// IDLE    | waiting; prog_en wins over mem_valid
// ACCESS  | RAM clocked with the bus request
// CAPTURE | read data from RAM registered into mem_rdata
// RESP    | mem_ready pulse
// PROG    | loader owns the RAMs
module bootram_ctrl
    import bootram_pkg::*;
#(
    parameter int ADDR_W     = bootram_pkg::ADDR_W,
    parameter int BYTE_LANES = bootram_pkg::BYTE_LANES
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    mem_valid,
    input  logic [31:0]             mem_addr,
    input  logic [31:0]             mem_wdata,
    input  logic [3:0]              mem_wstrb,
    output logic                    mem_ready,
    output logic [31:0]             mem_rdata,
    input  logic                    prog_en,
    input  logic                    prog_start,
    input  logic                    prog_valid,
    output logic                    prog_ready,
    input  logic [7:0]              prog_data,
    output logic                    prog_wrap,
    output logic [ADDR_W-1:0]       ram_ad,
    output logic                    ram_ce,
    output logic                    ram_oce,
    output logic [BYTE_LANES-1:0]   ram_wre,
    output logic [8*BYTE_LANES-1:0] ram_din,
    input  logic [8*BYTE_LANES-1:0] ram_dout
);

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       ram_ad_q, ram_ad_d;
    logic                    ram_ce_q, ram_ce_d;
    logic [BYTE_LANES-1:0]   ram_wre_q, ram_wre_d;
    logic [8*BYTE_LANES-1:0] ram_din_q, ram_din_d;
    logic [31:0]             rdata_q, rdata_d;

    logic                    ld_accept;
    logic [ADDR_W+1:0]       ld_byte_addr;
    logic                    unused_addr;

    assign unused_addr = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};

    bootram_loader #(.ADDR_W(ADDR_W)) u_loader (
        .clk          (clk),
        .resetn       (resetn),
        .active_i     (state_q == ST_PROG),
        .busy_i       (ram_ce_q),
        .prog_en_i    (prog_en),
        .prog_start_i (prog_start),
        .prog_valid_i (prog_valid),
        .prog_ready_o (prog_ready),
        .accept_o     (ld_accept),
        .byte_addr_o  (ld_byte_addr),
        .prog_wrap_o  (prog_wrap)
    );

    always_comb begin
        state_d   = state_q;
        ram_ad_d  = ram_ad_q;
        ram_ce_d  = 1'b0;
        ram_wre_d = '0;
        ram_din_d = ram_din_q;
        rdata_d   = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (prog_en) begin
                    state_d = ST_PROG;
                end else if (mem_valid) begin
                    state_d   = ST_ACCESS;
                    ram_ad_d  = mem_addr[ADDR_W+1:2];
                    ram_ce_d  = 1'b1;
                    ram_wre_d = mem_wstrb;
                    ram_din_d = mem_wdata;
                end
            end
            // Direction comes from the registered strobes, so the bus is not
            // resampled once the request has been taken.
            ST_ACCESS:  state_d = (ram_wre_q != '0) ? ST_RESP : ST_CAPTURE;
            ST_CAPTURE: begin
                rdata_d = ram_dout;
                state_d = ST_RESP;
            end
            ST_RESP:    state_d = ST_IDLE;
            ST_PROG: begin
                if (ld_accept) begin
                    ram_ad_d  = ld_byte_addr[ADDR_W+1:2];
                    ram_ce_d  = 1'b1;
                    ram_wre_d = BYTE_LANES'(1) << ld_byte_addr[1:0];
                    ram_din_d = {BYTE_LANES{prog_data}};
                end else if (!prog_en && !ram_ce_q) begin
                    // Leave only after any in-flight byte write has landed.
                    state_d = ST_IDLE;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            ram_ad_q  <= '0;
            ram_ce_q  <= 1'b0;
            ram_wre_q <= '0;
            ram_din_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            ram_ad_q  <= ram_ad_d;
            ram_ce_q  <= ram_ce_d;
            ram_wre_q <= ram_wre_d;
            ram_din_q <= ram_din_d;
            rdata_q   <= rdata_d;
        end
    end

    assign mem_ready = (state_q == ST_RESP);
    assign mem_rdata = rdata_q;
    assign ram_ad    = ram_ad_q;
    assign ram_ce    = ram_ce_q;
    assign ram_oce   = 1'b1;
    assign ram_wre   = ram_wre_q;
    assign ram_din   = ram_din_q;

endmodule

// File: tb/tb_bootram_ctrl.sv
module tb_bootram_ctrl;

    localparam int ADDR_W = 11;
    localparam int LANES  = 4;

    logic              clk;
    logic              resetn;
    logic              mem_valid;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ready;
    logic [31:0]       mem_rdata;
    logic              prog_en;
    logic              prog_start;
    logic              prog_valid;
    logic              prog_ready;
    logic [7:0]        prog_data;
    logic              prog_wrap;
    logic [ADDR_W-1:0] ram_ad;
    logic              ram_ce;
    logic              ram_oce;
    logic [LANES-1:0]  ram_wre;
    logic [31:0]       ram_din;
    logic [31:0]       ram_dout;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    bootram_ctrl #(.ADDR_W(ADDR_W), .BYTE_LANES(LANES)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .prog_en    (prog_en),
        .prog_start (prog_start),
        .prog_valid (prog_valid),
        .prog_ready (prog_ready),
        .prog_data  (prog_data),
        .prog_wrap  (prog_wrap),
        .ram_ad     (ram_ad),
        .ram_ce     (ram_ce),
        .ram_oce    (ram_oce),
        .ram_wre    (ram_wre),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane RAM model: bypass read mode, 1-cycle latency.
    logic [7:0] lane_mem [LANES][2048];
    always @(posedge clk) begin
        if (ram_ce) begin
            for (int i = 0; i < LANES; i++) begin
                if (ram_wre[i]) begin
                    lane_mem[i][ram_ad] <= ram_din[8*i +: 8];
                    ram_dout[8*i +: 8]  <= ram_din[8*i +: 8];
                end else begin
                    ram_dout[8*i +: 8]  <= lane_mem[i][ram_ad];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, output logic [31:0] rdata,
                            output int lat);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = strb;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!mem_ready && lat < 40);
        rdata     = mem_rdata;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic start);
        int n = 0;
        prog_data  = d;
        prog_valid = 1'b1;
        while (!prog_ready && n < 40) begin
            tick();
            n++;
        end
        if (!prog_ready) chk("prog_ready_wait", {31'b0, prog_ready}, 32'd1);
        prog_start = start;
        tick();
        prog_valid = 1'b0;
        prog_start = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_mem_ready"},  {31'b0, mem_ready},  32'd0);
        chk({pfx, "_mem_rdata"},  mem_rdata,           32'd0);
        chk({pfx, "_prog_ready"}, {31'b0, prog_ready}, 32'd0);
        chk({pfx, "_prog_wrap"},  {31'b0, prog_wrap},  32'd0);
        chk({pfx, "_ram_ce"},     {31'b0, ram_ce},     32'd0);
        chk({pfx, "_ram_wre"},    {28'b0, ram_wre},    32'd0);
        chk({pfx, "_ram_ad"},     {21'b0, ram_ad},     32'd0);
        chk({pfx, "_ram_din"},    ram_din,             32'd0);
        chk({pfx, "_ram_oce"},    {31'b0, ram_oce},    32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        logic        seen;

        resetn     = 1'b0;
        mem_valid  = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        mem_wstrb  = 4'h0;
        prog_en    = 1'b0;
        prog_start = 1'b0;
        prog_valid = 1'b0;
        prog_data  = 8'h0;

        tick(); tick(); tick();
        chk_reset_outputs("rst");
        resetn = 1'b1;
        tick();

        // Preload word 0x10 and read it back.
        bus_xfer(32'h40, 32'hDEADBEEF, 4'hF, rd, lat);
        chk("preload_lat", lat, 32'd2);
        tick();
        chk("write_ready_pulse", {31'b0, mem_ready}, 32'd0);

        bus_xfer(32'h40, 32'h0, 4'h0, rd, lat);
        chk("read_lat", lat, 32'd3);
        chk("read_data", rd, 32'hDEADBEEF);
        tick();
        chk("read_ready_pulse", {31'b0, mem_ready}, 32'd0);
        chk("rdata_hold", mem_rdata, 32'hDEADBEEF);

        // Partial write, lanes 0 and 2.
        bus_xfer(32'h40, 32'h11223344, 4'b0101, rd, lat);
        chk("pwrite_lat", lat, 32'd2);
        tick();
        bus_xfer(32'h40, 32'h0, 4'h0, rd, lat);
        chk("pwrite_readback", rd, 32'hDE22BE44);
        tick();

        // Loader: four bytes into word 0.
        prog_en    = 1'b1;
        prog_start = 1'b1;
        tick();
        prog_start = 1'b0;
        chk("ld_wrap_clear", {31'b0, prog_wrap}, 32'd0);
        send_byte(8'h13, 1'b0);
        chk("ld_ready_in_write", {31'b0, prog_ready}, 32'd0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        prog_en = 1'b0;
        tick(); tick();
        bus_xfer(32'h0, 32'h0, 4'h0, rd, lat);
        chk("ld_read_lat", lat, 32'd3);
        chk("ld_word0", rd, 32'h00000513);
        tick();

        // Counter retained across prog_en drop: next byte lands at byte 4.
        prog_en = 1'b1;
        tick();
        send_byte(8'h77, 1'b0);
        prog_en = 1'b0;
        tick(); tick();
        bus_xfer(32'h4, 32'h0, 4'h0, rd, lat);
        chk("ld_retain_lane0", {24'b0, rd[7:0]}, 32'h77);
        tick();

        // prog_start together with an accepted byte: byte to 0, next to 1.
        prog_en = 1'b1;
        tick();
        send_byte(8'hC3, 1'b1);
        send_byte(8'h99, 1'b0);
        prog_en = 1'b0;
        tick(); tick();
        bus_xfer(32'h0, 32'h0, 4'h0, rd, lat);
        chk("ld_start_coincident", rd, 32'h000099C3);
        tick();

        // Contention: read and prog_en in the same IDLE cycle.
        mem_valid = 1'b1;
        mem_addr  = 32'h40;
        mem_wstrb = 4'h0;
        prog_en   = 1'b1;
        seen      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_ready) seen = 1'b1;
        end
        chk("cont_stalled", {31'b0, seen}, 32'd0);
        chk("cont_prog_ready", {31'b0, prog_ready}, 32'd1);
        prog_en = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!mem_ready && lat < 40);
        rd        = mem_rdata;
        mem_valid = 1'b0;
        chk("cont_lat", lat, 32'd4);
        chk("cont_data", rd, 32'hDE22BE44);
        tick();

        // Wrap: 8193 bytes from address 0.
        prog_en    = 1'b1;
        prog_start = 1'b1;
        tick();
        prog_start = 1'b0;
        for (int j = 1; j <= 8193; j++) begin
            send_byte((j == 8193) ? 8'h5A : 8'(j), 1'b0);
            if (j == 8191) chk("wrap_before", {31'b0, prog_wrap}, 32'd0);
            if (j == 8192) chk("wrap_after", {31'b0, prog_wrap}, 32'd1);
        end
        prog_en = 1'b0;
        tick(); tick();
        chk("wrap_sticky", {31'b0, prog_wrap}, 32'd1);
        bus_xfer(32'h0, 32'h0, 4'h0, rd, lat);
        chk("wrap_word0", rd, 32'h0403025A);
        tick();

        // Reset during CAPTURE.
        mem_valid = 1'b1;
        mem_addr  = 32'h40;
        mem_wstrb = 4'h0;
        tick();
        tick();
        resetn    = 1'b0;
        mem_valid = 1'b0;
        tick();
        chk_reset_outputs("capt_rst");
        resetn = 1'b1;
        seen   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (mem_ready) seen = 1'b1;
        end
        chk("capt_rst_no_ready", {31'b0, seen}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/bootram_ctrl.md
BOOTRAM_CTRL -- requirements
Module: bootram_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 11, word-address width of each 2Kx8 byte-lane RAM.
REQ-002 Parameter: BYTE_LANES, default 4, number of byte-lane RAMs forming one 32-bit word.
REQ-003 clk  in  1  single clock for all logic; lane RAMs share it.
REQ-004 resetn  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 mem_valid  in  1  CPU native-bus request, already address-decoded for this slave.
REQ-006 mem_addr  in  32  byte address; bits [ADDR_W+1:2] used.
REQ-007 mem_wdata  in  32  write data.
REQ-008 mem_wstrb  in  4  byte write strobes; 0000 = read.
REQ-009 mem_ready  out  1  one-cycle completion pulse.
REQ-010 mem_rdata  out  32  read data, valid while mem_ready=1.
REQ-011 prog_en  in  1  level; grants the byte loader ownership of the RAMs.
REQ-012 prog_start  in  1  pulse; clears the loader byte counter to 0.
REQ-013 prog_valid / prog_ready  in / out  1 / 1  loader byte handshake.
REQ-014 prog_data  in  8  loader byte.
REQ-015 prog_wrap  out  1  sticky: byte counter wrapped past the top address.
REQ-016 ram_ad  out  ADDR_W  shared lane word address.
REQ-017 ram_ce, ram_oce  out  1, 1  lane clock enable and output-register enable (ram_oce tied 1).
REQ-018 ram_wre  out  4  per-lane write enable.
REQ-019 ram_din / ram_dout  out / in  32 / 32  lane data; lane i on bits [8i+7:8i]; lane RAM is bypass read mode, 1-cycle read latency.

Function
REQ-020 All RAM-port outputs SHALL be registered; no combinational path from mem_* or prog_* to ram_*.
REQ-021 FSM states: IDLE, ACCESS, CAPTURE, RESP, PROG.
REQ-022 IDLE: prog_en=1 -> PROG (takes priority over mem_valid in the same cycle); else mem_valid=1 -> ACCESS, registering ram_ad=mem_addr[12:2], ram_ce=1, ram_wre=mem_wstrb, ram_din=mem_wdata.
REQ-023 ACCESS: RAM is clocked; ram_ce and ram_wre deassert next cycle; write -> RESP, read -> CAPTURE.
REQ-024 CAPTURE: mem_rdata <= ram_dout -> RESP.
REQ-025 RESP: mem_ready=1 for exactly one cycle -> IDLE; mem_valid is not resampled until back in IDLE.
REQ-026 Latency, valid first high at cycle N in IDLE: write mem_ready at N+2; read at N+3.
REQ-027 Partial writes: only lanes with wstrb bit set are written; other lanes retain contents.
REQ-028 mem_rdata SHALL hold its last captured value outside RESP.
REQ-029 A bus transaction already past IDLE SHALL complete even if prog_en rises; PROG is entered only from IDLE.
REQ-030 PROG: prog_ready=1 while prog_en=1 and no write is in flight; on prog_valid&prog_ready, write prog_data to lane cnt[1:0] at word cnt[12:2] (single ram_wre bit), then cnt++.
REQ-031 Loader throughput: one byte accepted every 2 cycles (accept, write); prog_ready=0 in the write cycle.
REQ-032 Counter is 13 bits; 8191 -> 0 wraps and sets prog_wrap; prog_wrap clears only on prog_start or reset.
REQ-033 prog_start clears cnt in any state; if coincident with an accepted byte, the byte goes to address 0 and cnt becomes 1.
REQ-034 prog_en falling: finish any in-flight byte write, then -> IDLE; cnt is retained.
REQ-035 mem_valid during PROG is stalled: mem_ready stays 0 until service after PROG exits.

Reset
REQ-036 resetn=0 SHALL force: state IDLE, mem_ready=0, mem_rdata=0, prog_ready=0, prog_wrap=0, cnt=0, ram_ce=0, ram_wre=0, ram_ad=0, ram_din=0; ram_oce=1.
REQ-037 Reset mid-transaction abandons it without a mem_ready pulse; an in-flight RAM write may or may not land.

Structure
REQ-038 Shared package bootram_pkg holds ADDR_W, BYTE_LANES, and the FSM state enum.
REQ-039 Byte counter, wrap flag, and loader handshake SHALL be one sub-module, bootram_loader; lane RAMs are instantiated by the parent, not inside this block.

Verification
REQ-040 Read: preload word 0x10 = 0xDEADBEEF; valid at N, addr 0x40, wstrb 0 -> mem_ready at N+3, rdata 0xDEADBEEF.
REQ-041 Partial write: word 0x10 = 0xDEADBEEF; write 0x11223344 with wstrb 0101 -> ready at N+2; readback 0xDE22BE44.
REQ-042 Loader: prog_start, then bytes 0x13,0x05,0x00,0x00 -> word 0 = 0x00000513; bus read of addr 0 after prog_en falls returns 0x00000513.
REQ-043 Wrap: 8193 bytes loaded -> prog_wrap=1 after byte 8192; byte 8193 overwrites lane 0 of word 0.
REQ-044 Contention: mem_valid read and prog_en rise in the same IDLE cycle -> PROG first; mem_ready occurs 3 cycles after return to IDLE.
REQ-045 Reset during CAPTURE -> no mem_ready pulse, all outputs at REQ-036 values the next cycle.
